// File: rtl/wb_stage_skid_reg_pkg.sv
// Shared write-back pipeline types and constants.
// Imported by the MEM->WB skid register slice.
package pipe_pkg;

   localparam int WB_DATA_W  = 16;
   localparam int WB_ADDR_W  = 4;
   localparam int WB_NUM_SRC = 4;
   localparam int WB_SEL_W   = 2;
   localparam int WB_CNT_W   = 16;

   localparam logic [WB_SEL_W-1:0] WB_SEL_ALU   = 2'd0;
   localparam logic [WB_SEL_W-1:0] WB_SEL_SHIFT = 2'd1;
   localparam logic [WB_SEL_W-1:0] WB_SEL_MEM   = 2'd2;
   localparam logic [WB_SEL_W-1:0] WB_SEL_LINK  = 2'd3;

   typedef struct packed {
      logic [WB_SEL_W-1:0]             sel;
      logic                            wr_en;
      logic [WB_ADDR_W-1:0]            wr_addr;
      logic [WB_NUM_SRC*WB_DATA_W-1:0] src;
   } wb_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/wb_stage_skid_reg_if.sv
// MEM->WB stage bus: upstream handshake, write-back outputs,
// forwarding snoop and stall counter.
interface wb_stage_skid_reg_if #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 16
);
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [SEL_W-1:0]          in_sel;
   logic                      in_wr_en;
   logic [ADDR_W-1:0]         in_wr_addr;
   logic [NUM_SRC*DATA_W-1:0] in_src;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_wr_en;
   logic [ADDR_W-1:0]         out_wr_addr;
   logic [DATA_W-1:0]         out_wr_data;
   logic                      fwd_valid;
   logic [ADDR_W-1:0]         fwd_addr;
   logic [DATA_W-1:0]         fwd_data;
   logic [CNT_W-1:0]          stall_cnt;

   modport master (
      output flush, in_valid, in_sel, in_wr_en,
      output in_wr_addr, in_src, out_ready,
      input  in_ready, out_valid, out_wr_en,
      input  out_wr_addr, out_wr_data,
      input  fwd_valid, fwd_addr, fwd_data, stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_sel, in_wr_en,
      input  in_wr_addr, in_src, out_ready,
      output in_ready, out_valid, out_wr_en,
      output out_wr_addr, out_wr_data,
      output fwd_valid, fwd_addr, fwd_data, stall_cnt
   );
endinterface

// File: rtl/wb_stage_skid_reg_src_mux.sv
// Write-back source select; a select past the last source gives 0.
module wb_src_mux #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 16,
   parameter int SEL_W   = 2
) (
   input  logic [NUM_SRC*DATA_W-1:0] src,
   input  logic [SEL_W-1:0]          sel,
   output logic [DATA_W-1:0]         data
);

   always_comb begin
      data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) data = src[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/wb_stage_skid_reg.sv
// Elastic MEM->WB register with 2-entry skid buffer, flush,
// forwarding snoop and saturating stall counter.
module wb_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W  = WB_DATA_W,
   parameter int ADDR_W  = WB_ADDR_W,
   parameter int NUM_SRC = WB_NUM_SRC,
   parameter int SEL_W   = WB_SEL_W,
   parameter int CNT_W   = WB_CNT_W
) (
   input logic                 clk,
   input logic                 reset,
   wb_stage_skid_reg_if.slave  bus
);

   typedef struct packed {
      logic [SEL_W-1:0]          sel;
      logic                      wr_en;
      logic [ADDR_W-1:0]         wr_addr;
      logic [NUM_SRC*DATA_W-1:0] src;
   } entry_t;

   entry_t      main_q;
   entry_t      skid_q;
   entry_t      in_e;
   logic        main_valid;
   logic        skid_valid;
   logic        main_v_nxt;
   logic        skid_v_nxt;
   logic        main_ld;
   logic        main_from_skid;
   logic        skid_ld;
   logic        accept;
   logic        pop;
   skid_state_e state;
   logic [CNT_W-1:0]  stall_q;
   logic [DATA_W-1:0] wr_data;

   assign in_e.sel     = bus.in_sel;
   assign in_e.wr_en   = bus.in_wr_en;
   assign in_e.wr_addr = bus.in_wr_addr;
   assign in_e.src     = bus.in_src;

   // in_ready comes straight from the skid flop, never from out_ready
   assign bus.in_ready = !skid_valid;
   assign accept       = bus.in_valid & !skid_valid;
   assign pop          = main_valid & bus.out_ready;

   always_comb begin
      state = ST_EMPTY;
      if (skid_valid)      state = ST_TWO;
      else if (main_valid) state = ST_ONE;
   end

   always_comb begin
      main_v_nxt     = main_valid;
      skid_v_nxt     = skid_valid;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               main_v_nxt = 1'b1;
               main_ld    = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               skid_v_nxt = 1'b1;
               skid_ld    = 1'b1;
            end else if (accept) begin
               main_ld = 1'b1;
            end else if (pop) begin
               main_v_nxt = 1'b0;
            end
         end
         ST_TWO: begin
            if (pop) begin
               main_from_skid = 1'b1;
               skid_v_nxt     = 1'b0;
            end
         end
         default: ;
      endcase
      // flush drops everything and leaves the data flops alone
      if (bus.flush) begin
         main_v_nxt     = 1'b0;
         skid_v_nxt     = 1'b0;
         main_ld        = 1'b0;
         main_from_skid = 1'b0;
         skid_ld        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
         stall_q    <= '0;
      end else begin
         main_valid <= main_v_nxt;
         skid_valid <= skid_v_nxt;
         if (main_ld)             main_q <= in_e;
         else if (main_from_skid) main_q <= skid_q;
         if (skid_ld) skid_q <= in_e;
         if (main_valid && !bus.out_ready && !(&stall_q))
            stall_q <= stall_q + 1'b1;
      end
   end

   wb_src_mux #(
      .NUM_SRC (NUM_SRC),
      .DATA_W  (DATA_W),
      .SEL_W   (SEL_W)
   ) u_mux (
      .src  (main_q.src),
      .sel  (main_q.sel),
      .data (wr_data)
   );

   assign bus.out_valid   = main_valid;
   assign bus.out_wr_en   = main_valid & main_q.wr_en;
   assign bus.out_wr_addr = main_q.wr_addr;
   assign bus.out_wr_data = wr_data;
   assign bus.fwd_valid   = main_valid & main_q.wr_en;
   assign bus.fwd_addr    = main_q.wr_addr;
   assign bus.fwd_data    = wr_data;
   assign bus.stall_cnt   = stall_q;

endmodule
